// File: rtl/dmem_word_port_if.sv
// -----------------------------------------------------------------------------
// dmem_word_port_if
//   Bundles the CPU request/response channel and the line-memory channel of
//   dmem_word_port.
//   slave  : the view used by dmem_word_port (request consumer, memory initiator)
//   master : the view used by the environment (CPU + line memory)
//   CPU side   : flush, req_valid/req_ready, req_we, req_addr, req_wdata,
//                resp_valid, resp_rdata
//   Memory side: mem_addr, mem_wen, mem_wdata, mem_rdata (combinational read)
// -----------------------------------------------------------------------------
interface dmem_word_port_if #(
  parameter int DSIZE   = 16,
  parameter int LINE_AW = 12,
  parameter int WPL     = 16
);
  localparam int WAW = $clog2(WPL);

  logic                     flush;
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [LINE_AW+WAW-1:0]   req_addr;
  logic [DSIZE-1:0]         req_wdata;
  logic                     resp_valid;
  logic [DSIZE-1:0]         resp_rdata;
  logic [LINE_AW-1:0]       mem_addr;
  logic                     mem_wen;
  logic [DSIZE*WPL-1:0]     mem_wdata;
  logic [DSIZE*WPL-1:0]     mem_rdata;

  modport slave (
    input  flush, req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, mem_addr, mem_wen, mem_wdata
  );

  modport master (
    output flush, req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, mem_addr, mem_wen, mem_wdata
  );
endinterface

// File: rtl/dmem_word_port.sv
// -----------------------------------------------------------------------------
// dmem_word_port
//   Word-granular load/store initiator in front of a 256-bit line data memory.
//   Keeps a one-line buffer; loads that hit the buffer are answered without a
//   memory access, misses fetch the line, and every store is written through as
//   a full-line read-modify-write so memory always holds current data.
//   Ports:
//     clk    clock, all state on posedge
//     rst_n  asynchronous active-low reset
//     bus    dmem_word_port_if.slave (CPU request/response + line memory)
//   Word order at the memory: write word i -> mem_wdata[16i +: 16];
//   read word i -> mem_rdata[255-16i -: 16]. The buffer is kept in word-index
//   order, so both directions are converted here.
//   Latency from accept edge T: load hit T+1, load miss T+2, store hit T+2,
//   store miss T+3. One request in flight at most.
// -----------------------------------------------------------------------------
module dmem_word_port #(
  parameter int DSIZE   = 16,
  parameter int LINE_AW = 12,
  parameter int WPL     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  dmem_word_port_if.slave     bus
);
  localparam int WAW = $clog2(WPL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef logic [WPL-1:0][DSIZE-1:0] line_t;

  state_t             state;
  logic               buf_valid;
  logic [LINE_AW-1:0] tag;
  line_t              buf_q;
  line_t              buf_d;

  // Request latched at accept time.
  logic               we_q;
  logic [LINE_AW-1:0] line_q;
  logic [WAW-1:0]     word_q;
  logic [DSIZE-1:0]   wdata_q;

  logic [LINE_AW-1:0] req_line;
  logic [WAW-1:0]     req_word;
  logic               accept;
  logic               hit;

  assign req_line = bus.req_addr[LINE_AW+WAW-1:WAW];
  assign req_word = bus.req_addr[WAW-1:0];
  assign accept   = (state == IDLE) && bus.req_valid;
  // A flush in the accept cycle forces a miss so the line is refetched.
  assign hit      = buf_valid && (tag == req_line) && !bus.flush;

  // Next buffer contents: store-hit merge in IDLE, line capture (plus store
  // merge) in FILL; otherwise the buffer holds.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    buf_d = buf_q;
    case (state)
      IDLE: begin
        if (accept && hit && bus.req_we) buf_d[req_word] = bus.req_wdata;
      end
      FILL: begin
        for (int i = 0; i < WPL; i++) begin
          buf_d[i] = bus.mem_rdata[DSIZE*(WPL-i)-1 -: DSIZE];
        end
        if (we_q) buf_d[word_q] = wdata_q;
      end
      default: ;
    endcase
  end

  // Single FSM process; all outputs are registered and set on entry to the
  // state that owns them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      buf_valid      <= 1'b0;
      tag            <= '0;
      // NOTE: the line buffer is a flop array (not a RAM macro), so it takes a
      // defined reset value like any other register.
      buf_q          <= '0;
      we_q           <= 1'b0;
      line_q         <= '0;
      word_q         <= '0;
      wdata_q        <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.mem_addr   <= '0;
      bus.mem_wen    <= 1'b0;
      bus.mem_wdata  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      buf_q <= buf_d;
      case (state)
        IDLE: begin
          if (bus.flush) buf_valid <= 1'b0;
          if (accept) begin
            we_q          <= bus.req_we;
            line_q        <= req_line;
            word_q        <= req_word;
            wdata_q       <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            if (!hit) begin
              state        <= FILL;
              bus.mem_addr <= req_line;
            end else if (bus.req_we) begin
              state         <= WRITE;
              bus.mem_addr  <= tag;
              bus.mem_wen   <= 1'b1;
              bus.mem_wdata <= buf_d;
            end else begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_rdata <= buf_d[req_word];
            end
          end
        end

        FILL: begin
          tag       <= line_q;
          buf_valid <= 1'b1;
          if (we_q) begin
            // mem_addr already holds line_q, which is the new tag.
            state         <= WRITE;
            bus.mem_wen   <= 1'b1;
            bus.mem_wdata <= buf_d;
          end else begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= buf_d[word_q];
          end
        end

        WRITE: begin
          state          <= RESP;
          bus.mem_wen    <= 1'b0;
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= buf_d[word_q];
        end

        RESP: begin
          state          <= IDLE;
          bus.resp_valid <= 1'b0;
          bus.req_ready  <= 1'b1;
        end

        default: begin
          state          <= IDLE;
          bus.mem_wen    <= 1'b0;
          bus.resp_valid <= 1'b0;
          bus.req_ready  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_word_port.sv
// -----------------------------------------------------------------------------
// tb_dmem_word_port
//   Self-checking bench for dmem_word_port. A word-array line memory serves
//   the DUT; a flat word-addressed reference memory plus a "which line is
//   buffered" record predict load data, latency and write activity.
// -----------------------------------------------------------------------------
module tb_dmem_word_port;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  dmem_word_port_if bus ();

  dmem_word_port dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Physical memory, word-addressed {line, word}.
  logic [15:0] phys    [65536];
  // Reference model state.
  logic [15:0] ref_mem [65536];
  bit          ref_valid;
  logic [11:0] ref_line;

  int checks = 0;
  int errors = 0;

  always_comb begin
    bus.mem_rdata = '0;
    for (int i = 0; i < 16; i++) begin
      bus.mem_rdata[255-16*i -: 16] = phys[{bus.mem_addr, 4'(i)}];
    end
  end

  always @(posedge clk) begin
    if (bus.mem_wen) begin
      for (int i = 0; i < 16; i++) begin
        phys[{bus.mem_addr, 4'(i)}] <= bus.mem_wdata[16*i +: 16];
      end
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: word store/load with a one-line buffer record.
  task automatic model_step(input bit we, input logic [15:0] addr, input logic [15:0] wd,
                            input bit fl, output logic [15:0] p_rdata, output int p_lat,
                            output int p_wen);
    bit h;
    h = ref_valid && (ref_line == addr[15:4]) && !fl;
    if (we) p_lat = h ? 2 : 3;
    else    p_lat = h ? 1 : 2;
    p_wen = we ? 1 : 0;
    if (we) ref_mem[addr] = wd;
    p_rdata   = ref_mem[addr];
    ref_valid = 1'b1;
    ref_line  = addr[15:4];
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("ready_timeout", 0, 1);
  endtask

  // One complete request: wait for ready, present it for the accept edge,
  // then watch up to 8 cycles for the response.
  task automatic issue(input bit we, input logic [15:0] addr, input logic [15:0] wd,
                       input bit fl, output logic [15:0] rdata, output int lat,
                       output int wen_cnt, output logic [11:0] waddr,
                       output logic [255:0] wdata, output logic [15:0] p_rdata,
                       output int p_lat, output int p_wen);
    rdata = '0; lat = -1; wen_cnt = 0; waddr = '0; wdata = '0;
    wait_ready();
    model_step(we, addr, wd, fl, p_rdata, p_lat, p_wen);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.flush     = fl;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (bus.mem_wen) begin
        wen_cnt++;
        waddr = bus.mem_addr;
        wdata = bus.mem_wdata;
      end
      if (bus.resp_valid) begin
        rdata = bus.resp_rdata;
        lat   = n;
        break;
      end
    end
  endtask

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          flush;
    logic [15:0] exp_rdata;
    int          exp_lat;
    int          exp_wen;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [15:0]  rd, prd;
    int           lat, plat, wen, pwen;
    logic [11:0]  wa;
    logic [255:0] wdat, exp_line;
    logic [11:0]  pool [4];
    logic [15:0]  q [$];
    logic [15:0]  pa, pb;
    int           acc;

    for (int a = 0; a < 65536; a++) begin
      phys[a] = 16'(a) ^ 16'h5A00;
    end
    for (int i = 0; i < 16; i++) phys[{12'h005, 4'(i)}] = 16'h0500 + 16'(i);
    for (int a = 0; a < 65536; a++) ref_mem[a] = phys[a];
    ref_valid = 1'b0;
    ref_line  = '0;

    bus.flush = 1'b0; bus.req_valid = 1'b0; bus.req_we = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0;

    tbl[0] = '{1'b0, 16'h0053, 16'h0000, 1'b0, 16'h0503, 2, 0};
    tbl[1] = '{1'b0, 16'h005F, 16'h0000, 1'b0, 16'h050F, 1, 0};
    tbl[2] = '{1'b1, 16'h0057, 16'hBEEF, 1'b0, 16'hBEEF, 2, 1};
    tbl[3] = '{1'b0, 16'h0057, 16'h0000, 1'b1, 16'hBEEF, 2, 0};
    tbl[4] = '{1'b0, 16'h0050, 16'h0000, 1'b0, 16'h0500, 1, 0};
    tbl[5] = '{1'b0, 16'h0123, 16'h0000, 1'b0, 16'h5B23, 2, 0};
    tbl[6] = '{1'b1, 16'h0120, 16'h7777, 1'b0, 16'h7777, 2, 1};
    tbl[7] = '{1'b0, 16'h0120, 16'h0000, 1'b0, 16'h7777, 1, 0};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_req_ready",  bus.req_ready,  1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_mem_addr",   bus.mem_addr,   0);
    check("rst_mem_wen",    bus.mem_wen,    0);
    check("rst_mem_wdata",  bus.mem_wdata,  0);
    rst_n = 1'b1;

    // Store miss to the very last word right after reset.
    issue(1'b1, 16'hFFFF, 16'h1234, 1'b0, rd, lat, wen, wa, wdat, prd, plat, pwen);
    check("t4_lat",      lat, 3);
    check("t4_wen",      wen, 1);
    check("t4_waddr",    wa, 12'hFFF);
    check("t4_wdata_hi", wdat[255:240], 16'h1234);
    check("t4_rdata",    rd, 16'h1234);

    // Directed vector table.
    for (int v = 0; v < 8; v++) begin
      issue(tbl[v].we, tbl[v].addr, tbl[v].wdata, tbl[v].flush,
            rd, lat, wen, wa, wdat, prd, plat, pwen);
      check($sformatf("tbl%0d_rdata", v), rd,  tbl[v].exp_rdata);
      check($sformatf("tbl%0d_lat", v),   lat, tbl[v].exp_lat);
      check($sformatf("tbl%0d_wen", v),   wen, tbl[v].exp_wen);
      if (tbl[v].we) check($sformatf("tbl%0d_waddr", v), wa, tbl[v].addr[15:4]);
      if (v == 2) begin
        for (int i = 0; i < 16; i++)
          exp_line[16*i +: 16] = (i == 7) ? 16'hBEEF : 16'h0500 + 16'(i);
        check("t3_wdata_line", wdat, exp_line);
      end
    end

    // valid held high across busy cycles, two back-to-back loads.
    wait_ready();
    model_step(1'b0, 16'h0AB3, 16'h0, 1'b0, pa, plat, pwen);
    model_step(1'b0, 16'h0AB9, 16'h0, 1'b0, pb, plat, pwen);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'h0AB3;
    @(posedge clk);
    #1 bus.req_addr = 16'h0AB9;
    acc = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) check("t5_ready_busy", bus.req_ready, 0);
      if (bus.resp_valid) begin
        q.push_back(bus.resp_rdata);
        check("t5_ready_in_resp", bus.req_ready, 0);
      end
      if (acc == 1 && bus.req_ready) begin
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        acc = 2;
      end
    end
    bus.req_valid = 1'b0;
    check("t5_resp_count", q.size(), 2);
    if (q.size() >= 1) check("t5_resp0", q[0], pa);
    if (q.size() >= 2) check("t5_resp1", q[1], pb);

    // Reset in the middle of a store-hit WRITE.
    issue(1'b0, 16'h0050, 16'h0, 1'b0, rd, lat, wen, wa, wdat, prd, plat, pwen);
    check("t6_pre_rdata", rd, prd);
    wait_ready();
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 16'h0051; bus.req_wdata = 16'hDEAD;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("t6_wen_in_write", bus.mem_wen, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_wen_dropped",   bus.mem_wen,    0);
    check("t6_resp_dropped",  bus.resp_valid, 0);
    check("t6_ready_restore", bus.req_ready,  1);
    ref_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 16'h0051, 16'h0, 1'b0, rd, lat, wen, wa, wdat, prd, plat, pwen);
    check("t6_post_lat",   lat, 2);
    check("t6_post_rdata", rd, 16'h0501);

    // Randomized traffic against the reference model.
    pool[0] = 12'h005; pool[1] = 12'h012; pool[2] = 12'h0AB; pool[3] = 12'hFFF;
    for (int t = 0; t < 150; t++) begin
      bit          r_we, r_fl;
      logic [15:0] r_addr, r_wd;
      if ($urandom_range(9) == 0) begin
        wait_ready();
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        ref_valid = 1'b0;
      end
      r_we   = 1'($urandom_range(1));
      r_fl   = ($urandom_range(7) == 0);
      r_addr = {pool[$urandom_range(3)], 4'($urandom_range(15))};
      r_wd   = 16'($urandom);
      issue(r_we, r_addr, r_wd, r_fl, rd, lat, wen, wa, wdat, prd, plat, pwen);
      check("rnd_rdata", rd,  prd);
      check("rnd_lat",   lat, plat);
      check("rnd_wen",   wen, pwen);
    end

    // Write-through: memory must match the reference word image.
    @(negedge clk);
    for (int l = 0; l < 4; l++) begin
      for (int w = 0; w < 16; w++) begin
        check("mem_image", phys[{pool[l], 4'(w)}], ref_mem[{pool[l], 4'(w)}]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
